// File: rtl/fixed_activation_pkg.sv
// Shared helpers for the fixed-point activation blocks: slope quantisation,
// saturating signed narrowing and the per-beat sign-mask vector type.
package fixed_activation_pkg;

  localparam int MASK_MAX_P = 64;

  // Widest mask a beat can carry; blocks use the low P bits.
  typedef logic [MASK_MAX_P-1:0] mask_vec_t;

  function automatic int quantise_slope(input real slope, input int frac_bits);
    return $rtoi(slope * (2.0 ** frac_bits));
  endfunction

  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] value,
                                                   input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/leakyrelu_mask_fifo.sv
// Synchronous FIFO of sign-mask words. No bypass in either direction: a word
// written in one cycle is visible at the head from the next cycle on.
module leakyrelu_mask_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               i_wr_data,
  input  logic                           i_wr_valid,
  output logic                           o_wr_ready,
  output logic [WIDTH-1:0]               o_rd_data,
  output logic                           o_rd_valid,
  input  logic                           i_rd_ready,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("leakyrelu_mask_fifo: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // Extra wrap bit distinguishes full (tops differ) from empty (equal).
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign o_wr_ready = !w_full;
  assign o_rd_valid = !w_empty;
  assign o_rd_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count    = r_wr_ptr - r_rd_ptr;

  assign w_push = i_wr_valid && !w_full;
  assign w_pop  = i_rd_ready && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fixed_leakyrelu_backward.sv
// LeakyReLU backward pass: buffers forward-input signs, then passes or scales
// each upstream gradient by the quantised negative slope.
module fixed_leakyrelu_backward
  import fixed_activation_pkg::*;
#(
  parameter int  DATA_IN_0_PRECISION_0      = 8,
  parameter int  DATA_IN_0_PRECISION_1      = 3,
  parameter int  GRAD_PRECISION_0           = 8,
  parameter int  GRAD_PRECISION_1           = 3,
  parameter int  PARALLELISM_DIM_0          = 1,
  parameter int  PARALLELISM_DIM_1          = 1,
  parameter real NEGATIVE_SLOPE             = 0.5,
  parameter int  NEGATIVE_SLOPE_PRECISION_0 = 8,
  parameter int  NEGATIVE_SLOPE_PRECISION_1 = 7,
  parameter int  MASK_FIFO_DEPTH            = 16,
  localparam int P  = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
  localparam int GW = GRAD_PRECISION_0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]     data_in_0 [P],
  input  logic                                 data_in_0_valid,
  output logic                                 data_in_0_ready,
  input  logic [GW-1:0]                        grad_out_0 [P],
  input  logic                                 grad_out_0_valid,
  output logic                                 grad_out_0_ready,
  output logic [GW-1:0]                        grad_in_0 [P],
  output logic                                 grad_in_0_valid,
  input  logic                                 grad_in_0_ready,
  output logic [$clog2(MASK_FIFO_DEPTH+1)-1:0] mask_count
);

  localparam int SW             = NEGATIVE_SLOPE_PRECISION_0;
  localparam int SF             = NEGATIVE_SLOPE_PRECISION_1;
  localparam int NEG_SLOPE_QUAN = quantise_slope(NEGATIVE_SLOPE, SF);
  localparam logic signed [SW-1:0] SLOPE_W = SW'(NEG_SLOPE_QUAN);

  generate
    if (P > MASK_MAX_P) begin : g_bad_p
      $error("fixed_leakyrelu_backward: P exceeds MASK_MAX_P");
    end
  endgenerate

  mask_vec_t    w_mask_push;
  logic [P-1:0] w_mask_head;
  logic         w_mask_valid;
  logic         w_out_free;
  logic         w_fire;
  logic [GW-1:0] w_scaled [P];

  logic          r_valid;
  logic [GW-1:0] r_grad [P];

  always_comb begin
    w_mask_push = '0;
    for (int i = 0; i < P; i++) begin
      w_mask_push[i] = data_in_0[i][DATA_IN_0_PRECISION_0-1];
    end
  end

  leakyrelu_mask_fifo #(
    .WIDTH (P),
    .DEPTH (MASK_FIFO_DEPTH)
  ) u_mask_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_data  (w_mask_push[P-1:0]),
    .i_wr_valid (data_in_0_valid),
    .o_wr_ready (data_in_0_ready),
    .o_rd_data  (w_mask_head),
    .o_rd_valid (w_mask_valid),
    .i_rd_ready (w_fire),
    .o_count    (mask_count)
  );

  // Join: a gradient beat is taken only when a mask is waiting and the
  // output register is free or draining this cycle.
  assign w_out_free       = !r_valid || grad_in_0_ready;
  assign grad_out_0_ready = w_mask_valid && w_out_free;
  assign w_fire           = grad_out_0_valid && grad_out_0_ready;

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_elem
      logic signed [GW+SW-1:0] w_prod;
      logic signed [GW+SW-1:0] w_shifted;
      logic signed [63:0]      w_sat;

      assign w_prod      = $signed(grad_out_0[gi]) * SLOPE_W;
      assign w_shifted   = w_prod >>> SF;
      assign w_sat       = sat_narrow(64'(w_shifted), GW);
      assign w_scaled[gi] = w_mask_head[gi] ? w_sat[GW-1:0] : grad_out_0[gi];
      assign grad_in_0[gi] = r_grad[gi];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_grad[gi] <= '0;
        end else if (w_fire) begin
          r_grad[gi] <= w_scaled[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
    end else if (grad_in_0_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign grad_in_0_valid = r_valid;

endmodule

// File: tb/tb_fixed_leakyrelu_backward.sv
// Directed bench for fixed_leakyrelu_backward (8/3 gradients, slope 0.5 -> 64).
module tb_fixed_leakyrelu_backward;

  logic       clk;
  logic       rst;
  logic [7:0] data_in_0 [1];
  logic       data_in_0_valid;
  logic       data_in_0_ready;
  logic [7:0] grad_out_0 [1];
  logic       grad_out_0_valid;
  logic       grad_out_0_ready;
  logic [7:0] grad_in_0 [1];
  logic       grad_in_0_valid;
  logic       grad_in_0_ready;
  logic [4:0] mask_count;

  int checks = 0;
  int errors = 0;

  fixed_leakyrelu_backward dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .grad_out_0       (grad_out_0),
    .grad_out_0_valid (grad_out_0_valid),
    .grad_out_0_ready (grad_out_0_ready),
    .grad_in_0        (grad_in_0),
    .grad_in_0_valid  (grad_in_0_valid),
    .grad_in_0_ready  (grad_in_0_ready),
    .mask_count       (mask_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    data_in_0_valid = 1'b0;
    grad_out_0_valid = 1'b0;
    grad_in_0_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mask_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", mask_count); end
    checks++; if (grad_in_0_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", grad_in_0_valid); end
    checks++; if (grad_in_0[0] !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", grad_in_0[0]); end
    checks++; if (data_in_0_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got %b want 1", data_in_0_ready); end
    checks++; if (grad_out_0_ready !== 1'b0) begin errors++; $display("FAIL reset_gout_ready got %b want 0", grad_out_0_ready); end
    $display("reset: count=%0d valid=%b", mask_count, grad_in_0_valid);
    rst = 1'b0;
  endtask

  // Single transactions: push x, present g, expect result one cycle after fire.
  task automatic test_arith(input string name, input logic [7:0] xs [4],
                            input logic [7:0] gs [4], input logic [7:0] exps [4]);
    for (int i = 0; i < 4; i++) begin
      data_in_0[0] = xs[i]; data_in_0_valid = 1'b1;
      @(posedge clk); #1;
      data_in_0_valid = 1'b0;
      grad_out_0[0] = gs[i]; grad_out_0_valid = 1'b1; grad_in_0_ready = 1'b1;
      @(negedge clk);
      checks++; if (grad_out_0_ready !== 1'b1) begin errors++; $display("FAIL %s_gready[%0d] got %b want 1", name, i, grad_out_0_ready); end
      checks++; if (grad_in_0_valid !== 1'b0) begin errors++; $display("FAIL %s_prevalid[%0d] got %b want 0", name, i, grad_in_0_valid); end
      @(posedge clk); #1;
      grad_out_0_valid = 1'b0;
      checks++; if (grad_in_0_valid !== 1'b1) begin errors++; $display("FAIL %s_valid[%0d] got %b want 1", name, i, grad_in_0_valid); end
      checks++; if (grad_in_0[0] !== exps[i]) begin errors++; $display("FAIL %s_data[%0d] x=%h g=%h got %h want %h", name, i, xs[i], gs[i], grad_in_0[0], exps[i]); end
      $display("%s: x=%h g=%h -> %h", name, xs[i], gs[i], grad_in_0[0]);
      @(posedge clk); #1;
      checks++; if (grad_in_0_valid !== 1'b0) begin errors++; $display("FAIL %s_clear[%0d] got %b want 0", name, i, grad_in_0_valid); end
    end
  endtask

  task automatic test_full();
    grad_out_0_valid = 1'b0;
    data_in_0_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in_0[0] = (i % 2 == 0) ? 8'hF8 : 8'h08;
      @(posedge clk); #1;
    end
    checks++; if (mask_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", mask_count); end
    checks++; if (data_in_0_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", data_in_0_ready); end
    data_in_0[0] = 8'h00;
    grad_out_0[0] = 8'h10; grad_out_0_valid = 1'b1; grad_in_0_ready = 1'b1;
    @(negedge clk);
    checks++; if (data_in_0_ready !== 1'b0) begin errors++; $display("FAIL full_held_ready got %b want 0", data_in_0_ready); end
    @(posedge clk); #1;
    grad_out_0_valid = 1'b0;
    checks++; if (mask_count !== 5'd15) begin errors++; $display("FAIL full_pop_count got %0d want 15", mask_count); end
    checks++; if (data_in_0_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got %b want 1", data_in_0_ready); end
    checks++; if (grad_in_0[0] !== 8'h08) begin errors++; $display("FAIL full_pop_data got %h want 08", grad_in_0[0]); end
    @(posedge clk); #1;
    data_in_0_valid = 1'b0;
    checks++; if (mask_count !== 5'd16) begin errors++; $display("FAIL full_push17_count got %0d want 16", mask_count); end
    $display("full: count=%0d", mask_count);
    apply_reset();
  endtask

  task automatic test_empty_stall();
    grad_out_0[0] = 8'h20; grad_out_0_valid = 1'b1; grad_in_0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (grad_out_0_ready !== 1'b0 || grad_in_0_valid !== 1'b0) begin
        errors++; $display("FAIL empty_stall[%0d] got ready=%b valid=%b want 0/0", i, grad_out_0_ready, grad_in_0_valid);
      end
      @(posedge clk); #1;
    end
    data_in_0[0] = 8'h80; data_in_0_valid = 1'b1;
    @(posedge clk); #1;
    data_in_0_valid = 1'b0;
    checks++; if (grad_in_0_valid !== 1'b0) begin errors++; $display("FAIL empty_bypass got %b want 0", grad_in_0_valid); end
    @(negedge clk);
    checks++; if (grad_out_0_ready !== 1'b1) begin errors++; $display("FAIL empty_ready got %b want 1", grad_out_0_ready); end
    @(posedge clk); #1;
    grad_out_0_valid = 1'b0;
    checks++; if (grad_in_0_valid !== 1'b1 || grad_in_0[0] !== 8'h10) begin
      errors++; $display("FAIL empty_fire got valid=%b data=%h want 1/10", grad_in_0_valid, grad_in_0[0]);
    end
    $display("empty_stall: out=%h", grad_in_0[0]);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] xs [8];
    logic [7:0] gs [8];
    logic [7:0] exps [8];
    int got;
    xs   = '{8'hF8, 8'h08, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'hC0, 8'h01};
    gs   = '{8'h10, 8'h10, 8'hFD, 8'hFD, 8'h20, 8'h20, 8'hE0, 8'hF0};
    exps = '{8'h08, 8'h10, 8'hFE, 8'hFD, 8'h10, 8'h20, 8'hF0, 8'hF0};
    data_in_0_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in_0[0] = xs[i];
      @(posedge clk); #1;
    end
    data_in_0_valid = 1'b0;
    grad_in_0_ready = 1'b1;
    got = 0;
    fork
      begin : producer
        for (int i = 0; i < 8; i++) begin
          logic ok;
          ok = 1'b0;
          grad_out_0[0] = gs[i]; grad_out_0_valid = 1'b1;
          for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = grad_out_0_ready;
            @(posedge clk); #1;
          end
          checks++; if (!ok) begin errors++; $display("FAIL b2b_send[%0d] got stalled want accepted", i); end
        end
        grad_out_0_valid = 1'b0;
      end
      begin : consumer
        logic       hold;
        logic [7:0] hold_data;
        logic [1:0] pat [4];
        pat = '{2'd1, 2'd0, 2'd0, 2'd1};
        hold = 1'b0;
        hold_data = '0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
          @(negedge clk);
          if (hold) begin
            checks++; if (grad_in_0_valid !== 1'b1 || grad_in_0[0] !== hold_data) begin
              errors++; $display("FAIL b2b_stable got valid=%b data=%h want 1/%h", grad_in_0_valid, grad_in_0[0], hold_data);
            end
          end
          hold = 1'b0;
          if (grad_in_0_valid === 1'b1 && grad_in_0_ready) begin
            checks++; if (grad_in_0[0] !== exps[got]) begin
              errors++; $display("FAIL b2b_data[%0d] got %h want %h", got, grad_in_0[0], exps[got]);
            end
            $display("b2b: beat %0d -> %h", got, grad_in_0[0]);
            got++;
          end else if (grad_in_0_valid === 1'b1) begin
            hold = 1'b1;
            hold_data = grad_in_0[0];
          end
          @(posedge clk); #1;
          grad_in_0_ready = pat[(cyc + 1) % 4][0];
        end
      end
    join
    checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count got %0d want 8", got); end
    grad_in_0_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mask_count !== 5'd0 || grad_in_0_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got count=%0d valid=%b want 0/0", mask_count, grad_in_0_valid);
    end
  endtask

  task automatic test_reset_mid();
    data_in_0_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in_0[0] = 8'hF0 + 8'(i);
      @(posedge clk); #1;
    end
    data_in_0_valid = 1'b0;
    grad_in_0_ready = 1'b0;
    grad_out_0[0] = 8'h40; grad_out_0_valid = 1'b1;
    @(posedge clk); #1;
    grad_out_0_valid = 1'b0;
    checks++; if (mask_count !== 5'd5 || grad_in_0_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre got count=%0d valid=%b want 5/1", mask_count, grad_in_0_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (mask_count !== 5'd0) begin errors++; $display("FAIL mid_count got %0d want 0", mask_count); end
    checks++; if (grad_in_0_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", grad_in_0_valid); end
    checks++; if (grad_in_0[0] !== 8'h00) begin errors++; $display("FAIL mid_data got %h want 00", grad_in_0[0]); end
    checks++; if (data_in_0_ready !== 1'b1) begin errors++; $display("FAIL mid_din_ready got %b want 1", data_in_0_ready); end
    $display("reset_mid: count=%0d valid=%b", mask_count, grad_in_0_valid);
    grad_in_0_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] ax [4];
    logic [7:0] ag [4];
    logic [7:0] ae [4];
    rst = 1'b1;
    data_in_0[0] = '0; data_in_0_valid = 1'b0;
    grad_out_0[0] = '0; grad_out_0_valid = 1'b0;
    grad_in_0_ready = 1'b1;
    test_reset();
    ax = '{8'hF8, 8'h08, 8'hFF, 8'h00};
    ag = '{8'h10, 8'h10, 8'hFD, 8'hFD};
    ae = '{8'h08, 8'h10, 8'hFE, 8'hFD};
    test_arith("arith", ax, ag, ae);
    ax = '{8'h80, 8'h7F, 8'hC0, 8'hFF};
    ag = '{8'h80, 8'h80, 8'h7F, 8'h01};
    ae = '{8'hC0, 8'h80, 8'h3F, 8'h00};
    test_arith("edge", ax, ag, ae);
    test_full();
    test_empty_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
